// File: rtl/pipeline_run_monitor.sv
`default_nettype none
// ============================================================================
// Module : pipeline_run_monitor
// Gates the pipeline for a programmed number of enabled cycles (free-running
// or single-stepped) and checks captured writebacks against an expected table.
// Rev    : 1.0
// ============================================================================
module pipeline_run_monitor #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_cycles,
    input  logic              step_mode,
    input  logic              step,
    input  logic              abort,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              exp_we,
    input  logic [AW-1:0]     exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              pipe_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [AW:0]       trace_cnt,
    output logic              wrapped,
    output logic              mismatch,
    output logic [AW-1:0]     first_bad
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STEP_WAIT = 3'd2,
        S_STEP      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_num;
    logic [AW-1:0]       r_wptr;
    logic [DATA_W-1:0]   r_trace [DEPTH];
    logic [DATA_W-1:0]   r_exp   [DEPTH];

    logic                w_idle;
    logic                w_start_ok;
    logic                w_en;
    logic                w_cap;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_last;

    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    // abort takes priority: a start in the same cycle is dropped
    assign w_start_ok = start && !abort && w_idle;
    assign w_en       = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_cap      = w_en && wb_valid;
    assign w_cnt_inc  = cycle_cnt + CNT_W'(1);
    assign w_last     = (w_cnt_inc == r_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        pipe_en = 1'b0;
        busy    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    if (num_cycles == '0) begin
                        w_next = S_DONE;
                    end else if (step_mode) begin
                        w_next = S_STEP_WAIT;
                    end else begin
                        w_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                pipe_en = 1'b1;
                busy    = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_STEP_WAIT: begin
                busy = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (step) begin
                    w_next = S_STEP;
                end
            end
            S_STEP: begin
                pipe_en = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_STEP_WAIT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num     <= '0;
            r_wptr    <= '0;
            done      <= 1'b0;
            cycle_cnt <= '0;
            trace_cnt <= '0;
            wrapped   <= 1'b0;
            mismatch  <= 1'b0;
            first_bad <= '0;
            rd_data   <= '0;
        end else begin
            rd_data <= r_trace[rd_addr];
            if (w_start_ok) begin
                r_num     <= num_cycles;
                r_wptr    <= '0;
                done      <= (num_cycles == '0);
                cycle_cnt <= '0;
                trace_cnt <= '0;
                wrapped   <= 1'b0;
                mismatch  <= 1'b0;
                first_bad <= '0;
            end else begin
                if (w_en) begin
                    cycle_cnt <= w_cnt_inc;
                end
                if (w_en && (w_next == S_DONE)) begin
                    done <= 1'b1;
                end
                if (w_cap) begin
                    r_wptr <= r_wptr + AW'(1);
                    if (trace_cnt == c_depth) begin
                        wrapped <= 1'b1;
                    end else begin
                        trace_cnt <= trace_cnt + (AW+1)'(1);
                        // pre-wrap, the write pointer equals the capture index
                        if (wb_data != r_exp[r_wptr]) begin
                            mismatch <= 1'b1;
                            if (!mismatch) begin
                                first_bad <= r_wptr;
                            end
                        end
                    end
                end
            end
        end
    end

    // Storage arrays are deliberately unreset so their contents survive rst_n
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_trace[r_wptr] <= wb_data;
        end
        if (exp_we && w_idle) begin
            r_exp[exp_addr] <= exp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_monitor.sv
`default_nettype none
// Testbench for pipeline_run_monitor: directed runs plus randomized runs,
// all checked against a run-level behavioural model on every cycle.
module tb_pipeline_run_monitor;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_cycles = '0;
    logic              step_mode = 1'b0;
    logic              step = 1'b0;
    logic              abort = 1'b0;
    logic              wb_valid = 1'b0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              exp_we = 1'b0;
    logic [AW-1:0]     exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;
    logic [AW-1:0]     rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              pipe_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [AW:0]       trace_cnt;
    logic              wrapped;
    logic              mismatch;
    logic [AW-1:0]     first_bad;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    pipeline_run_monitor #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_cycles(num_cycles),
        .step_mode(step_mode), .step(step), .abort(abort),
        .wb_valid(wb_valid), .wb_data(wb_data),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .pipe_en(pipe_en), .busy(busy), .done(done), .cycle_cnt(cycle_cnt),
        .trace_cnt(trace_cnt), .wrapped(wrapped), .mismatch(mismatch),
        .first_bad(first_bad)
    );

    always #5 clk = ~clk;

    // Run-level model: a run is active, possibly in step mode with an armed step
    bit                m_active = 1'b0;
    bit                m_step = 1'b0;
    bit                m_armed = 1'b0;
    bit                m_done = 1'b0;
    bit                m_mis = 1'b0;
    bit                m_en = 1'b0;
    int                m_num = 0;
    int                m_cnt = 0;
    int                m_ncap = 0;
    int                m_fb = 0;
    logic [DATA_W-1:0] m_trace [DEPTH];
    bit                m_tv    [DEPTH];
    logic [DATA_W-1:0] m_exp   [DEPTH];
    logic [DATA_W-1:0] m_rd = '0;
    bit                m_rd_known = 1'b1;

    task automatic model_update();
        if (!rst_n) begin
            m_active = 0; m_step = 0; m_armed = 0; m_done = 0; m_mis = 0;
            m_cnt = 0; m_ncap = 0; m_fb = 0; m_rd = '0; m_rd_known = 1;
        end else begin
            m_en = m_active && (!m_step || m_armed);
            m_rd = m_trace[rd_addr];
            m_rd_known = m_tv[rd_addr];
            if (exp_we && !m_active) m_exp[exp_addr] = exp_data;
            if (!m_active && start && !abort) begin
                m_num = int'(num_cycles);
                m_cnt = 0; m_ncap = 0; m_mis = 0; m_fb = 0;
                m_done = (m_num == 0);
                m_active = (m_num != 0);
                m_step = step_mode;
                m_armed = 0;
            end else if (m_active) begin
                if (m_en) begin
                    m_cnt++;
                    if (wb_valid) begin
                        m_trace[m_ncap % DEPTH] = wb_data;
                        m_tv[m_ncap % DEPTH] = 1;
                        if (m_ncap < DEPTH && wb_data != m_exp[m_ncap]) begin
                            if (!m_mis) m_fb = m_ncap;
                            m_mis = 1;
                        end
                        m_ncap++;
                    end
                end
                if (abort) begin
                    m_active = 0;
                end else if (m_en && m_cnt == m_num) begin
                    m_active = 0;
                    m_done = 1;
                end else if (m_step) begin
                    m_armed = m_en ? 1'b0 : step;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_update();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL timeout %s: run still active, required to finish", name);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("pipe_en",   64'(pipe_en),   64'(m_active && (!m_step || m_armed)));
            check("busy",      64'(busy),      64'(m_active && !(m_step && m_armed)));
            check("done",      64'(done),      64'(m_done));
            check("cycle_cnt", 64'(cycle_cnt), 64'(m_cnt));
            check("trace_cnt", 64'(trace_cnt), 64'((m_ncap > DEPTH) ? DEPTH : m_ncap));
            check("wrapped",   64'(wrapped),   64'(m_ncap > DEPTH));
            check("mismatch",  64'(mismatch),  64'(m_mis));
            check("first_bad", 64'(first_bad), 64'(m_fb));
            if (m_rd_known) check("rd_data", 64'(rd_data), 64'(m_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic load_exp();
        for (int i = 0; i < DEPTH; i++) begin
            exp_we = 1; exp_addr = AW'(i); exp_data = DATA_W'(i + 1);
            tick();
        end
        exp_we = 0;
    endtask

    // Free run with data 1..8 then 0x1000+n; capture indices bad_a/bad_b get 0xDEAD
    task automatic free_run(input int num, input int bad_a, input int bad_b, output int n_en);
        int g;
        num_cycles = CNT_W'(num); step_mode = 0; start = 1;
        tick();
        start = 0; n_en = 0; g = 0;
        while (pipe_en && g < 200) begin
            wb_valid = 1;
            if (n_en == bad_a || n_en == bad_b) wb_data = 32'hDEAD;
            else if (n_en < DEPTH) wb_data = DATA_W'(n_en + 1);
            else wb_data = DATA_W'(32'h1000 + n_en);
            tick();
            n_en++; g++;
        end
        wb_valid = 0;
        if (g >= 200) timeout("free_run");
    endtask

    initial begin
        int n;
        int g;
        int nidle;
        tick(); tick();
        check("reset pipe_en",   64'(pipe_en),   64'(0));
        check("reset busy",      64'(busy),      64'(0));
        check("reset done",      64'(done),      64'(0));
        check("reset cycle_cnt", 64'(cycle_cnt), 64'(0));
        check("reset rd_data",   64'(rd_data),   64'(0));
        rst_n = 1;
        chk_en = 1;
        tick();
        load_exp();

        free_run(8, -1, -1, n);
        check("run8 en cycles", 64'(n),         64'(8));
        check("run8 done",      64'(done),      64'(1));
        check("run8 busy",      64'(busy),      64'(0));
        check("run8 trace_cnt", 64'(trace_cnt), 64'(8));
        check("run8 mismatch",  64'(mismatch),  64'(0));
        check("run8 cycle_cnt", 64'(cycle_cnt), 64'(8));

        free_run(8, 3, 6, n);
        check("bad mismatch",  64'(mismatch),  64'(1));
        check("bad first_bad", 64'(first_bad), 64'(3));

        free_run(11, -1, -1, n);
        check("wrap wrapped",   64'(wrapped),   64'(1));
        check("wrap trace_cnt", 64'(trace_cnt), 64'(8));
        check("wrap mismatch",  64'(mismatch),  64'(0));
        check("wrap cycle_cnt", 64'(cycle_cnt), 64'(11));
        rd_addr = '0;
        tick();
        check("wrap rd_data0", 64'(rd_data), 64'(32'h1008));

        num_cycles = 3; step_mode = 1; start = 1;
        tick();
        start = 0;
        check("step wait busy",    64'(busy),    64'(1));
        check("step wait pipe_en", 64'(pipe_en), 64'(0));
        n = 0;
        for (int i = 1; i <= 24; i++) begin
            if (pipe_en) begin
                wb_data = DATA_W'(n + 1);
                n++;
            end
            wb_valid = 1;
            step = (i % 6 == 5) || (i % 6 == 0);
            tick();
        end
        step = 0; wb_valid = 0;
        check("step en cycles", 64'(n),         64'(3));
        check("step done",      64'(done),      64'(1));
        check("step cycle_cnt", 64'(cycle_cnt), 64'(3));
        check("step mismatch",  64'(mismatch),  64'(0));

        num_cycles = 10; step_mode = 0; start = 1;
        tick();
        start = 0; n = 0;
        while (pipe_en && n < 20) begin
            abort = (n == 3); wb_valid = 1; wb_data = DATA_W'(n + 1);
            tick();
            n++;
        end
        abort = 0; wb_valid = 0;
        check("abort en cycles", 64'(n),         64'(4));
        check("abort done",      64'(done),      64'(0));
        check("abort cycle_cnt", 64'(cycle_cnt), 64'(4));
        check("abort busy",      64'(busy),      64'(0));
        num_cycles = 5; start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        check("start+abort busy",      64'(busy),      64'(0));
        check("start+abort pipe_en",   64'(pipe_en),   64'(0));
        check("start+abort cycle_cnt", 64'(cycle_cnt), 64'(4));

        num_cycles = 10; start = 1;
        tick();
        start = 0; wb_valid = 1;
        for (int k = 0; k < 4; k++) begin
            wb_data = DATA_W'(k + 1);
            tick();
        end
        #2 rst_n = 0;
        #1;
        check("rst pipe_en",   64'(pipe_en),   64'(0));
        check("rst busy",      64'(busy),      64'(0));
        check("rst cycle_cnt", 64'(cycle_cnt), 64'(0));
        check("rst trace_cnt", 64'(trace_cnt), 64'(0));
        check("rst done",      64'(done),      64'(0));
        @(negedge clk);
        #1;
        rst_n = 1; wb_valid = 0;
        tick();
        free_run(8, -1, -1, n);
        check("post-rst mismatch",  64'(mismatch),  64'(0));
        check("post-rst trace_cnt", 64'(trace_cnt), 64'(8));
        check("post-rst done",      64'(done),      64'(1));

        for (int r = 0; r < 40; r++) begin
            nidle = int'($urandom_range(1, 4));
            for (int k = 0; k < nidle; k++) begin
                exp_we = 1'($urandom_range(0, 1));
                exp_addr = AW'($urandom);
                exp_data = ($urandom_range(0, 1) == 0) ? $urandom : DATA_W'(k + 1);
                rd_addr = AW'($urandom);
                tick();
            end
            exp_we = 0;
            num_cycles = CNT_W'($urandom_range(0, 20));
            step_mode = 1'($urandom_range(0, 1));
            abort = ($urandom_range(0, 9) == 0);
            start = 1;
            tick();
            start = 0; abort = 0; g = 0;
            while (m_active && g < 300) begin
                wb_valid = ($urandom_range(0, 3) != 0);
                wb_data = ($urandom_range(0, 5) == 0) ? $urandom : m_exp[m_ncap % DEPTH];
                step = ($urandom_range(0, 2) == 0);
                abort = ($urandom_range(0, 49) == 0);
                start = ($urandom_range(0, 9) == 0);
                exp_we = 1'($urandom_range(0, 1));
                exp_addr = AW'($urandom);
                exp_data = $urandom;
                rd_addr = AW'($urandom);
                tick();
                g++;
            end
            wb_valid = 0; step = 0; abort = 0; start = 0; exp_we = 0;
            if (g >= 300) timeout("random run");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_run_monitor.md
# pipeline_run_monitor

Parametrised run controller and writeback trace checker for the pipeline core. It gates the pipeline for a programmed number of clock cycles, either free-running or single-stepped. While enabled, it captures every valid writeback value into a circular trace buffer and compares it against a preloaded expected table. Mismatches are flagged with the index of the first bad capture, so a directed run is checked without hand-written per-cycle waits.

## Interface
- DATA_W, 32, writeback data width
- DEPTH, 8, trace/expected entries; power of two, ≥2
- CNT_W, 16, cycle counter width
- AW, $clog2(DEPTH), derived address width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request pulse; accepted only in IDLE or DONE
- num_cycles  in  CNT_W  enabled cycles to run; sampled on accepted start
- step_mode  in  1  sampled on accepted start; 1 = single-step
- step  in  1  advance one cycle; used only in STEP_WAIT
- abort  in  1  terminate run
- wb_valid  in  1  writeback valid from pipeline
- wb_data  in  DATA_W  writeback value (mux output)
- exp_we  in  1  expected-table write; honoured only in IDLE/DONE
- exp_addr  in  AW  expected-table address
- exp_data  in  DATA_W  expected value
- rd_addr  in  AW  trace read address
- rd_data  out  DATA_W  trace entry, registered
- pipe_en  out  1  pipeline clock enable
- busy  out  1  state is RUN or STEP_WAIT
- done  out  1  run completed; held until next accepted start
- cycle_cnt  out  CNT_W  enabled cycles elapsed this run
- trace_cnt  out  AW+1  captures stored, saturates at DEPTH
- wrapped  out  1  sticky: more than DEPTH captures this run
- mismatch  out  1  sticky compare failure this run
- first_bad  out  AW  capture index of first mismatch

## Operation
- States: IDLE, RUN, STEP_WAIT, STEP, DONE. Reset → IDLE.
- Accepted start clears cycle_cnt, trace_cnt, write pointer, wrapped, mismatch, first_bad and done.
  - num_cycles=0 → DONE.
  - Else step_mode=0 → RUN; step_mode=1 → STEP_WAIT.
- RUN: pipe_en=1 each cycle. On the cycle where cycle_cnt reaches num_cycles → DONE.
- STEP_WAIT: pipe_en=0. A step pulse moves to STEP.
- STEP: pipe_en=1 for exactly one cycle, then → STEP_WAIT, or → DONE if num_cycles is reached. Step asserted in STEP is ignored.
- abort in RUN, STEP_WAIT or STEP → IDLE next edge; done stays 0.
  - abort and start in the same cycle: abort wins, start is dropped.
- Capture happens only when pipe_en && wb_valid:
  - write wb_data to trace[wptr]; wptr increments mod DEPTH;
  - trace_cnt increments, saturating at DEPTH;
  - the DEPTH+1th capture sets wrapped.
- Compare happens only for capture index n < DEPTH (pre-wrap): wb_data ≠ exp[n] sets mismatch.
  - On the first such failure, first_bad = n.
  - Later failures do not change first_bad.
- pipe_en and busy are Moore outputs of state. All other outputs are registered.
- Reset values: pipe_en, busy, done, cycle_cnt, trace_cnt, wrapped, mismatch, first_bad, rd_data = 0.
- Trace and expected arrays are not reset; their contents survive rst_n.
- Reset mid-run: immediate return to IDLE, pipe_en drops asynchronously, no partial done.

## Timing
- start sampled at edge t → pipe_en high from t through t+N, i.e. N cycles.
- done=1 and busy=0 after edge t+N.
- Capture and compare use the values present on the edge where pipe_en=1. mismatch is visible one cycle after the offending capture.
- step sampled at edge s in STEP_WAIT → pipe_en high for cycle s..s+1 only.
- rd_data: one-cycle latency from rd_addr. A same-cycle trace write to that address returns the old data.
- exp_we: write at the edge. Reads by compare in the same cycle are not possible, because exp_we is ignored while busy.

## Test plan
- Load exp[0..7]=1..8, start with num_cycles=8, step_mode=0, wb_valid=1, wb_data=1..8 → pipe_en high exactly 8 cycles, done=1, trace_cnt=8, mismatch=0, cycle_cnt=8.
- Same run but the 4th value is 0xDEAD → mismatch=1, first_bad=3. A second bad value at index 6 leaves first_bad=3.
- num_cycles=11, 11 valid captures → wrapped=1, trace_cnt=8, rd_addr=0 returns capture 8, no compare on captures 8..10.
- step_mode=1, num_cycles=3, step pulses at gaps of 5 cycles → pipe_en pulses 3 single cycles, done after the 3rd, cycle_cnt=3.
- abort at cycle 4 of a 10-cycle run → IDLE next edge, done=0, cycle_cnt=4. start+abort in the same cycle from IDLE → stays IDLE.
- rst_n low at cycle 5 of a run → pipe_en=0 immediately, all counters 0. The expected table is still intact for the next run.
